pipelined_sub16: RTL

- 2-stage pipelined 16-bit subtractor with borrow chain; the subtract-direction counterpart of the 16-bit carry look-ahead adder in the ALU datapath.
- Computes D = A - B - BIN (mod 2^16) plus borrow-out and N/Z/V flags.
- Low byte is resolved in stage 1, high byte in stage 2; the inter-byte borrow is registered between them.
- Valid/ready handshake on both sides, so the block sits between the operand-fetch and writeback stages and tolerates writeback stalls.

---
 rtl/pipelined_sub16.sv | 64 ++++++
 1 files changed

// File: rtl/pipelined_sub16.sv
// pipelined_sub16: two-stage 16-bit subtractor (low byte, then high byte) with
// a registered inter-byte borrow and valid/ready flow control on both sides.
module pipelined_sub16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        BIN,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] D,
    output logic        BOUT,
    output logic        N,
    output logic        Z,
    output logic        V
);
    logic       r_s1_valid, r_b1;
    logic [7:0] r_d_lo, r_a_hi, r_b_hi;
    logic [8:0] w_lo, w_hi;
    logic       w_s1_adv, w_s2_adv;
    assign w_s2_adv = !out_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;
    // bit 8 of each 9-bit difference is the borrow out of that byte
    assign w_lo = {1'b0, A[7:0]} - {1'b0, B[7:0]} - {8'b0, BIN};
    assign w_hi = {1'b0, r_a_hi} - {1'b0, r_b_hi} - {8'b0, r_b1};
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_b1       <= 1'b0;
            r_d_lo     <= 8'h0;
            r_a_hi     <= 8'h0;
            r_b_hi     <= 8'h0;
            out_valid  <= 1'b0;
            D          <= 16'h0;
            BOUT       <= 1'b0;
            N          <= 1'b0;
            Z          <= 1'b0;
            V          <= 1'b0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_d_lo <= w_lo[7:0];
                    r_b1   <= w_lo[8];
                    r_a_hi <= A[15:8];
                    r_b_hi <= B[15:8];
                end
            end
            if (w_s2_adv) begin
                out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    D    <= {w_hi[7:0], r_d_lo};
                    BOUT <= w_hi[8];
                    N    <= w_hi[7];
                    Z    <= ({w_hi[7:0], r_d_lo} == 16'h0);
                    V    <= (r_a_hi[7] != r_b_hi[7]) && (w_hi[7] != r_a_hi[7]);
                end
            end
        end
    end
endmodule
